// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment/anode constants and digit-index type for the 4-digit scan driver
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  // Cathode patterns, active-low, bit7 = dp (always off)
  localparam logic [7:0] SEG_ZERO  = 8'b11000000;
  localparam logic [7:0] SEG_ONE   = 8'b11111001;
  localparam logic [7:0] SEG_TWO   = 8'b10100100;
  localparam logic [7:0] SEG_THREE = 8'b10110000;
  localparam logic [7:0] SEG_FOUR  = 8'b10011001;
  localparam logic [7:0] SEG_FIVE  = 8'b10010010;
  localparam logic [7:0] SEG_SIX   = 8'b10000010;
  localparam logic [7:0] SEG_SEVEN = 8'b11111000;
  localparam logic [7:0] SEG_EIGHT = 8'b10000000;
  localparam logic [7:0] SEG_NINE  = 8'b10010000;
  localparam logic [7:0] SEG_DASH  = 8'b10111111;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_SLOT0 = 4'b1110;
  localparam logic [3:0] AN_SLOT1 = 4'b1101;
  localparam logic [3:0] AN_SLOT2 = 4'b1011;
  localparam logic [3:0] AN_SLOT3 = 4'b0111;
  localparam logic [3:0] AN_OFF   = 4'hF;

  function automatic logic [3:0] slot_anode(input digit_idx_t idx);
    case (idx)
      2'd0:    slot_anode = AN_SLOT0;
      2'd1:    slot_anode = AN_SLOT1;
      2'd2:    slot_anode = AN_SLOT2;
      default: slot_anode = AN_SLOT3;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low 7-segment decode, dash for 10..15
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = SEG_ONE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver with frame snapshot and adjust blink
// Optional LEAD_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_one,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  digit_idx_t    idx;
  digit_idx_t    idx_next;
  logic [3:0]    snap_min_ten, snap_min_one, snap_sec_ten, snap_sec_one;
  logic [3:0]    digit;
  logic [7:0]    dec_seg;
  logic          tick, frame_start, blink_blank, lz_blank;

  assign tick        = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign idx_next    = idx + 2'd1;
  assign frame_start = (idx == 2'd3);

  // Slot 0 opens a frame, so it shows the value being captured on this same edge.
  always_comb begin
    digit = snap_min_ten;
    case (idx_next)
      2'd0:    digit = frame_start ? sec_one : snap_sec_one;
      2'd1:    digit = snap_sec_ten;
      2'd2:    digit = snap_min_one;
      default: digit = snap_min_ten;
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit),
    .seg (dec_seg)
  );

  // Slots 0/1 are the seconds pair, 2/3 the minutes pair.
  assign blink_blank = adj && blink_phase && (sel ? ~idx_next[1] : idx_next[1]);

`ifdef LEAD_ZERO_BLANK_EN
  assign lz_blank = (idx_next == 2'd3) && (digit == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt  <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      idx          <= 2'd3;
      snap_min_ten <= 4'd0;
      snap_min_one <= 4'd0;
      snap_sec_ten <= 4'd0;
      snap_sec_one <= 4'd0;
      seg          <= SEG_BLANK;
      an           <= AN_OFF;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;

      if (adj) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end

      if (tick) begin
        idx <= idx_next;
        an  <= slot_anode(idx_next);
        seg <= (blink_blank || lz_blank) ? SEG_BLANK : dec_seg;
        if (frame_start) begin
          snap_min_ten <= min_ten;
          snap_min_one <= min_one;
          snap_sec_ten <= sec_ten;
          snap_sec_one <= sec_one;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (REFRESH_DIV=4, BLINK_DIV=16)
module tb_seg7_scan_driver;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic       adj, sel;
  logic [7:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .min_ten (min_ten),
    .min_one (min_one),
    .sec_ten (sec_ten),
    .sec_one (sec_one),
    .adj     (adj),
    .sel     (sel),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  // Model: n = edges since reset release, m = consecutive edges with adj high.
  logic [7:0] dec_tab [16];
  logic [3:0] snap [4];
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  int         n, m;
  logic       model_ok = 1'b0;

  initial begin
    dec_tab = '{8'b11000000, 8'b11111001, 8'b10100100, 8'b10110000,
                8'b10011001, 8'b10010010, 8'b10000010, 8'b11111000,
                8'b10000000, 8'b10010000, 8'b10111111, 8'b10111111,
                8'b10111111, 8'b10111111, 8'b10111111, 8'b10111111};
  end

  always @(posedge clk) begin
    int nn, slot;
    logic [3:0] dig;
    logic blank;
    if (!rst) begin
      n <= 0;
      m <= 0;
      for (int i = 0; i < 4; i++) snap[i] <= 4'd0;
      exp_seg <= 8'hFF;
      exp_an  <= 4'hF;
    end else begin
      nn = n + 1;
      n <= nn;
      m <= adj ? m + 1 : 0;
      if (nn % R == 0) begin
        slot = (nn / R + 3) % 4;
        dig  = (slot == 0) ? sec_one : snap[slot];
        if (slot == 0) begin
          snap[0] <= sec_one;
          snap[1] <= sec_ten;
          snap[2] <= min_one;
          snap[3] <= min_ten;
        end
        blank = adj && ((m / B) % 2 == 1) && (sel ? (slot < 2) : (slot >= 2));
`ifdef LEAD_ZERO_BLANK_EN
        if (slot == 3 && dig == 4'd0) blank = 1'b1;
`endif
        exp_an  <= 4'hF ^ (4'b0001 << slot);
        exp_seg <= blank ? 8'hFF : dec_tab[dig];
      end
    end
    model_ok <= 1'b1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_seg", seg, exp_seg);
      check("model_an", {4'h0, an}, {4'h0, exp_an});
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [7:0] s);
    check({name, "_an"}, {4'h0, an}, {4'h0, a});
    check({name, "_seg"}, seg, s);
  endtask

  initial begin
    rst = 1'b0; adj = 1'b0; sel = 1'b0;
    min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd3; sec_one = 4'd4;
    step(3);
    lit("reset", 4'hF, 8'hFF);
    rst = 1'b1;
    step(3);
    lit("pre_tick", 4'hF, 8'hFF);
    step(1);
    lit("scan0", 4'b1110, 8'b10011001);
    step(4);
    lit("scan1", 4'b1101, 8'b10110000);
    step(4);
    lit("scan2", 4'b1011, 8'b10100100);
    step(4);
    lit("scan3", 4'b0111, 8'b11111001);

    // Snapshot: change sec_one while idx==1
    step(8);
    sec_one = 4'd7;
    step(4);
    lit("snap_idx2", 4'b1011, 8'b10100100);
    step(4);
    lit("snap_idx3", 4'b0111, 8'b11111001);
    step(4);
    lit("snap_idx0", 4'b1110, 8'b11111000);

    // Blink minutes pair
    adj = 1'b1; sel = 1'b0;
    step(24);
    lit("blink_min2", 4'b1011, 8'hFF);
    step(4);
    lit("blink_min3", 4'b0111, 8'hFF);
    step(4);
    lit("blink_sec0", 4'b1110, 8'b11111000);
    step(8);
    lit("blink_vis2", 4'b1011, 8'b10100100);

    // Blink seconds pair, then drop adj mid-blank
    adj = 1'b0;
    step(1);
    adj = 1'b1; sel = 1'b1;
    step(23);
    lit("blink_sec_s0", 4'b1110, 8'hFF);
    adj = 1'b0;
    step(4);
    lit("adj_fall_s1", 4'b1101, 8'b10110000);

    // Invalid BCD then reset at idx2
    min_one = 4'hC;
    step(20);
    lit("dash", 4'b1011, 8'b10111111);
    rst = 1'b0;
    step(1);
    lit("mid_reset", 4'hF, 8'hFF);
    rst = 1'b1;
    step(3);
    lit("post_reset_wait", 4'hF, 8'hFF);
    step(1);
    lit("post_reset_tick", 4'b1110, 8'b11111000);

    // Leading zero on minutes tens
    min_ten = 4'd0;
    step(28);
`ifdef LEAD_ZERO_BLANK_EN
    lit("lead_zero", 4'b0111, 8'hFF);
`else
    lit("lead_zero", 4'b0111, 8'b11000000);
`endif
    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the stopwatch digit outputs. Takes four BCD digits (min_ten, min_one, sec_ten, sec_one) plus the adj/sel controls.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display: 8-bit active-low cathodes (dp is bit 7) and 4-bit active-low anodes.
- Provides an internal refresh prescaler, a frame-coherent digit snapshot, and adjust-mode blinking of the selected pair.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2.
- BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- min_ten  input  4  BCD minutes tens
- min_one  input  4  BCD minutes ones
- sec_ten  input  4  BCD seconds tens
- sec_one  input  4  BCD seconds ones
- adj  input  1  adjust mode; enables blinking
- sel  input  1  blink target: 0 = minutes pair, 1 = seconds pair
- seg  output  8  cathodes, active-low; bit7 = dp, held 1
- an  output  4  anodes, active-low

Behaviour:
- Reset: rst==0 at a posedge sets the following on that edge:
  - refresh count = 0, blink count = 0, blink_phase = 0
  - idx = 3, snapshot digits = 0
  - seg = 8'hFF, an = 4'hF
  - Reset mid-operation behaves identically. No partial frame completes.
- Prescaler: counts 0..REFRESH_DIV-1. tick = (count == REFRESH_DIV-1), and the count wraps to 0 on that edge.
- On a tick edge, idx <= (idx+1) mod 4. an and seg are registered on the same edge for the NEW idx, so the latency from tick to outputs is zero edges.
- Anode map:
  - idx0 -> 4'b1110 (sec_one)
  - idx1 -> 4'b1101 (sec_ten)
  - idx2 -> 4'b1011 (min_one)
  - idx3 -> 4'b0111 (min_ten)
- First tick after reset wraps idx 3 -> 0. an stays 4'hF until that tick.
- Snapshot:
  - On a tick with idx==3, all four input digits are captured into snapshot registers.
  - seg for the new idx0 uses the value captured on that same edge.
  - Input changes mid-frame are invisible until the next frame.
- Between ticks, seg and an hold.
- Decode, applied to snapshot digits:
  - 0 = 8'b11000000
  - 1 = 8'b11111001
  - 2 = 8'b10100100
  - 3 = 8'b10110000
  - 4 = 8'b10011001
  - 5 = 8'b10010010
  - 6 = 8'b10000010
  - 7 = 8'b11111000
  - 8 = 8'b10000000
  - 9 = 8'b10010000
  - 10..15 = dash 8'b10111111
- Blink:
  - While adj==1, the blink counter runs 0..BLINK_DIV-1 and blink_phase toggles at each wrap.
  - While adj==0, the counter and blink_phase are held at 0, so entering adjust always starts with the digits visible for one full half-period.
  - adj and sel are sampled at tick edges only.
  - If adj==1 and blink_phase==1 at a tick, a slot belonging to the selected pair gets seg = 8'hFF; an is still driven normally.
  - The unselected pair is never blanked.
- adj falling mid-blank: the next tick shows digits normally.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: in slot idx3, a snapshot min_ten==0 drives seg = 8'hFF with an = 4'b0111.
- Undefined: in the same case, the zero pattern 8'b11000000 is shown.
- Blink rules apply identically in both builds.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_ZERO..SEG_NINE, SEG_DASH, SEG_BLANK
  - anode constants AN_SLOT0..AN_SLOT3, AN_OFF
  - a 2-bit digit-index typedef
- One natural sub-module: seg7_decode, a combinational 4-bit BCD -> 8-bit segment mapping including the dash case. It is instantiated once on the muxed snapshot digit.
- Prescaler, blink counter, snapshot, and output registers live in the top module.

Test Plan:
- All tests use REFRESH_DIV=4 and BLINK_DIV=16.
- Reset: rst=0 for 3 edges -> seg=8'hFF, an=4'hF. Release rst -> on the 4th edge, an=4'b1110 and seg=pattern of sec_one.
- Scan with digits 1,2,3,4 (min_ten..sec_one), adj=0 -> repeating every 16 cycles:
  - an 1110 / seg 10011001
  - an 1101 / seg 10110000
  - an 1011 / seg 10100100
  - an 0111 / seg 11111001
- Snapshot: change sec_one 4 -> 7 while idx=1 -> idx2/idx3 slots unchanged, and 8'b11111000 first appears at the next idx0 tick.
- Blink:
  - adj=1, sel=0 -> min slots show 8'hFF only for ticks occurring 16..31 cycles after adj rose; sec slots stay unaffected.
  - Repeat with sel=1 -> the roles swap.
- Invalid BCD / reset: min_one=4'hC -> idx2 seg=8'b10111111. Then assert rst=0 at idx2 -> next edge seg=8'hFF, an=4'hF, and the first tick lights idx0.
- LEAD_ZERO_BLANK_EN, with min_ten=0:
  - Defined build -> idx3 an=0111, seg=8'hFF.
  - Undefined build -> seg=8'b11000000.
